// File: rtl/mux2a1ochobits_rr.sv
// rtl/mux2a1ochobits_rr.sv - two-lane 8-bit merge with per-lane FIFOs and round-robin output
module mux2a1ochobits_rr #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in0,
    input  logic [WIDTH-1:0] data_in0,
    input  logic             valid_in1,
    input  logic [WIDTH-1:0] data_in1,
    input  logic             out_ready,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             selector_out,
    output logic             full0,
    output logic             full1,
    output logic             empty0,
    output logic             empty1,
    output logic             overflow0,
    output logic             overflow1
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem0 [DEPTH];
    logic [WIDTH-1:0] mem1 [DEPTH];
    logic [PW-1:0]    wptr0, rptr0, wptr1, rptr1;
    logic [CW-1:0]    count0, count1;
    logic             last_grant;

    logic slot_free, pop0, pop1, grant_any;
    logic wr0, wr1, drop0, drop1;

    assign full0  = (count0 == CW'(DEPTH));
    assign full1  = (count1 == CW'(DEPTH));
    assign empty0 = (count0 == '0);
    assign empty1 = (count1 == '0);

    always_comb begin
        slot_free = !valid_out || out_ready;
        pop0 = 1'b0;
        pop1 = 1'b0;
        // Only words present at cycle start compete; a tie goes to the lane not granted last.
        if (slot_free) begin
            if (!empty0 && !empty1) begin
                pop0 = last_grant;
                pop1 = !last_grant;
            end else begin
                pop0 = !empty0;
                pop1 = !empty1;
            end
        end
        grant_any = pop0 || pop1;
        // A full lane still accepts a word when it is being popped in the same cycle.
        wr0   = valid_in0 && (!full0 || pop0);
        wr1   = valid_in1 && (!full1 || pop1);
        drop0 = valid_in0 && full0 && !pop0;
        drop1 = valid_in1 && full1 && !pop1;
    end

    always_ff @(posedge clk) begin
        if (!reset && wr0) begin
            mem0[wptr0] <= data_in0;
        end
        if (!reset && wr1) begin
            mem1[wptr1] <= data_in1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr0        <= '0;
            rptr0        <= '0;
            count0       <= '0;
            wptr1        <= '0;
            rptr1        <= '0;
            count1       <= '0;
            overflow0    <= 1'b0;
            overflow1    <= 1'b0;
            last_grant   <= 1'b1;
            valid_out    <= 1'b0;
            data_out     <= '0;
            selector_out <= 1'b0;
        end else begin
            if (wr0) begin
                wptr0 <= wptr0 + PW'(1);
            end
            if (wr1) begin
                wptr1 <= wptr1 + PW'(1);
            end
            if (pop0) begin
                rptr0 <= rptr0 + PW'(1);
            end
            if (pop1) begin
                rptr1 <= rptr1 + PW'(1);
            end
            count0    <= count0 + CW'(wr0) - CW'(pop0);
            count1    <= count1 + CW'(wr1) - CW'(pop1);
            overflow0 <= overflow0 || drop0;
            overflow1 <= overflow1 || drop1;

            // With no eligible lane the slot empties but data/selector keep their last values.
            if (slot_free) begin
                valid_out <= grant_any;
                if (grant_any) begin
                    data_out     <= pop1 ? mem1[rptr1] : mem0[rptr0];
                    selector_out <= pop1;
                    last_grant   <= pop1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux2a1ochobits_rr.sv
// tb/tb_mux2a1ochobits_rr.sv - scoreboard bench for the two-lane round-robin merge
module tb_mux2a1ochobits_rr;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in0, valid_in1, out_ready;
    logic [7:0] data_in0, data_in1;
    logic       valid_out, selector_out;
    logic [7:0] data_out;
    logic       full0, full1, empty0, empty1, overflow0, overflow1;

    int checks = 0;
    int errors = 0;
    logic [8:0] expq [$];

    mux2a1ochobits_rr #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .valid_in0(valid_in0), .data_in0(data_in0),
        .valid_in1(valid_in1), .data_in1(data_in1),
        .out_ready(out_ready),
        .valid_out(valid_out), .data_out(data_out), .selector_out(selector_out),
        .full0(full0), .full1(full1), .empty0(empty0), .empty1(empty1),
        .overflow0(overflow0), .overflow1(overflow1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_word(input logic sel, input logic [7:0] d);
        expq.push_back({sel, d});
    endtask

    // A transfer completes at the next rising edge whenever valid_out and out_ready are both high.
    always @(negedge clk) begin
        if (!reset && valid_out && out_ready) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got sel=%0d data=%0h expected none", selector_out, data_out);
            end else begin
                logic [8:0] e;
                e = expq.pop_front();
                if ({selector_out, data_out} !== e) begin
                    errors++;
                    $display("FAIL out_word: got sel=%0d data=%0h expected sel=%0d data=%0h",
                             selector_out, data_out, e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        valid_in0 = 1'b1; data_in0 = 8'hEE;
        valid_in1 = 1'b1; data_in1 = 8'hDD;
        out_ready = 1'b1;

        // 1: reset with both lanes driving
        tick(2);
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out, 8'h00);
        check("rst_selector", selector_out, 0);
        check("rst_empty0", empty0, 1);
        check("rst_empty1", empty1, 1);
        check("rst_full0", full0, 0);
        check("rst_full1", full1, 0);
        check("rst_overflow0", overflow0, 0);
        check("rst_overflow1", overflow1, 0);
        reset = 1'b0; valid_in0 = 1'b0; valid_in1 = 1'b0;
        tick(3);
        check("rst_nothing_stored", {empty0, empty1, valid_out}, 3'b110);

        // 3: both lanes, two words each, lane 0 wins the first tie
        valid_in0 = 1'b1; data_in0 = 8'h10; valid_in1 = 1'b1; data_in1 = 8'h20;
        expect_word(0, 8'h10); expect_word(1, 8'h20);
        expect_word(0, 8'h11); expect_word(1, 8'h21);
        tick();
        data_in0 = 8'h11; data_in1 = 8'h21;
        tick();
        valid_in0 = 1'b0; valid_in1 = 1'b0;
        check("rr_gap0", valid_out, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("rr_gap", valid_out, 1);
        end
        tick();
        check("rr_idle", valid_out, 0);

        // 2: single word, minimum latency, one-cycle output
        valid_in0 = 1'b1; data_in0 = 8'hA5;
        expect_word(0, 8'hA5);
        tick();
        valid_in0 = 1'b0;
        check("lat_not_yet", valid_out, 0);
        tick();
        check("lat_valid", valid_out, 1);
        check("lat_sel", selector_out, 0);
        tick();
        check("lat_one_cycle", valid_out, 0);

        // 4: stalled output, lane 1 fills and drops its fifth word
        out_ready = 1'b0;
        valid_in0 = 1'b1; data_in0 = 8'h50;
        tick();
        valid_in0 = 1'b0;
        tick();
        check("stall_held_valid", valid_out, 1);
        valid_in1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in1 = 8'h31 + 8'(i);
            tick();
            if (i == 3) begin
                check("stall_full1", full1, 1);
                check("stall_no_ovf_yet", overflow1, 0);
            end
        end
        valid_in1 = 1'b0;
        check("stall_ovf1", overflow1, 1);
        check("stall_full1_after", full1, 1);
        check("stall_data_stable", data_out, 8'h50);
        check("stall_sel_stable", selector_out, 0);
        expect_word(0, 8'h50);
        for (int i = 0; i < 4; i++) expect_word(1, 8'h31 + 8'(i));
        out_ready = 1'b1;
        tick();
        check("release_full1", full1, 0);
        tick(3);
        check("release_empty1", empty1, 1);
        tick(2);
        check("release_idle", valid_out, 0);

        // 5: write into a full lane in the same cycle it is popped
        out_ready = 1'b0;
        valid_in0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in0 = 8'h60 + 8'(i);
            tick();
        end
        check("fill_full0", full0, 1);
        check("fill_ovf0", overflow0, 0);
        for (int i = 0; i < 5; i++) expect_word(0, 8'h60 + 8'(i));
        expect_word(0, 8'h44);
        out_ready = 1'b1; data_in0 = 8'h44;
        tick();
        valid_in0 = 1'b0;
        check("pass_full0", full0, 1);
        check("pass_ovf0", overflow0, 0);
        tick(6);
        check("pass_drained", {empty0, valid_out}, 2'b10);

        // 6: reset mid-burst discards everything queued and in flight
        out_ready = 1'b0;
        valid_in0 = 1'b1; valid_in1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in0 = 8'h70 + 8'(i); data_in1 = 8'h80 + 8'(i);
            tick();
        end
        check("pre_rst_valid", valid_out, 1);
        check("pre_rst_ovf1", overflow1, 1);
        reset = 1'b1; data_in0 = 8'h99; data_in1 = 8'h98;
        tick();
        reset = 1'b0; valid_in0 = 1'b0; valid_in1 = 1'b0;
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_empty", {empty0, empty1}, 2'b11);
        check("mid_rst_ovf", {overflow0, overflow1}, 2'b00);
        check("mid_rst_full", {full0, full1}, 2'b00);
        out_ready = 1'b1;
        tick(8);
        check("post_rst_idle", valid_out, 0);

        check("scoreboard_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux2a1ochobits_rr.md
Name: mux2a1ochobits_rr

Overview:
- Merge block: collects two independent 8-bit valid-qualified lanes (lane 0, lane 1) and recombines them into one 8-bit output stream.
- Each lane is buffered in a small FIFO. The output is a registered, round-robin arbitrated stream with downstream backpressure.
- Tags each output word with its source lane (selector_out) so the stream can be split again downstream.
- Sits after the 1:2 eight-bit demux stage, at the merge point of the two paths.

Parameters:
- WIDTH, 8, data width of each lane and of the output.
- DEPTH, 4, entries per lane FIFO. Must be a power of 2, ≥2.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the rising edge where it is 1
- valid_in0  input  1  lane 0 word present this cycle
- data_in0  input  WIDTH  lane 0 data
- valid_in1  input  1  lane 1 word present this cycle
- data_in1  input  WIDTH  lane 1 data
- out_ready  input  1  downstream accepts the current output word
- valid_out  output  1  data_out holds a valid word (registered)
- data_out  output  WIDTH  merged data (registered)
- selector_out  output  1  source lane of data_out: 0 or 1 (registered)
- full0, full1  output  1  lane FIFO count == DEPTH
- empty0, empty1  output  1  lane FIFO count == 0
- overflow0, overflow1  output  1  sticky: a lane word was dropped

Behaviour:
- Reset (synchronous, active-high):
  - valid_out=0, data_out=0, selector_out=0.
  - Counts and pointers cleared: empty0/1=1, full0/1=0, overflow0/1=0.
  - last_grant=1, so lane 0 wins the first tie.
  - Reset has priority over every other event. Inputs are ignored in any cycle where reset=1. Any in-flight output word is discarded, not emitted.
- Flags:
  - full/empty are decoded from the registered counts, so they are glitch-free and valid from cycle start.
- Output slot and pop:
  - Output slot is free when valid_out=0 or out_ready=1.
  - When free, the arbiter pops one lane FIFO into the output register. Only FIFOs non-empty at cycle start are eligible.
  - A word written this cycle is not eligible this cycle. Minimum latency: valid_in sampled at edge n → valid_out=1 after edge n+1.
- Lane write:
  - On valid_inN=1 with countN<DEPTH, store at wptrN; wptrN increments modulo DEPTH.
  - If countN==DEPTH and lane N is popped in the same cycle, the write is accepted and the count is unchanged.
  - If countN==DEPTH and lane N is not popped, the word is dropped and overflowN←1. overflowN stays set until reset.
- Count update: countN += write_accepted − pop. Simultaneous write and pop on an empty FIFO is impossible, because an empty lane is not eligible for pop.
- Arbitration:
  - Both lanes non-empty: grant the lane ≠ last_grant.
  - One lane non-empty: grant that lane.
  - last_grant updates only on an actual grant.
  - No eligible lane and slot free: valid_out←0; data_out and selector_out hold their last values.
- Hold: valid_out=1 and out_ready=0 → data_out, selector_out, valid_out unchanged. No pop occurs.
- Throughput: max 1 output word/cycle total. Sustained per-lane input above half rate with both lanes active eventually fills the FIFOs.
- Order: FIFO order is preserved within a lane. Interleaving across lanes follows the round-robin rule only.

Test Plan:
1. Reset held 2 cycles with valid_in0=valid_in1=1 → valid_out=0, empty0=empty1=1, full0=full1=0, overflow0=overflow1=0; nothing stored.
2. valid_in0=1, data_in0=0xA5 for one cycle, out_ready=1 → after next edge: valid_out=1, data_out=0xA5, selector_out=0 for exactly one cycle, then valid_out=0.
3. Both lanes, 2 cycles: lane0 0x10,0x11; lane1 0x20,0x21; out_ready=1 → output sequence 0x10/sel0, 0x20/sel1, 0x11/sel0, 0x21/sel1, no gaps after the first.
4. Backpressure and overflow:
   - Setup: out_ready=0 with one word already in the output register; write 0x31..0x35 to lane1.
   - Check while stalled: data_out stable; full1=1 after 4 writes; 0x35 dropped; overflow1=1.
   - Release out_ready=1 → held word, then 0x31..0x34 in order, then empty1=1.
5. Lane0 full, out_ready=1, valid_in0=1 with 0x44 in the same cycle → write accepted, full0 stays 1, overflow0 stays 0; 0x44 later emitted after the four prior words.
6. Reset asserted mid-burst with 3 words queued in each lane → next cycle valid_out=0, both empty, overflow cleared; none of the queued words ever appear.
